// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB register: single-cycle for ALU ops, multi-cycle
// handshaked data-memory access for loads/stores with a bounded ack wait.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [15:0] r0data,
  input  logic [15:0] Din,
  input  logic [15:0] instructions4,
  input  logic        wEnable,
  input  logic        mux3sels4,
  input  logic        regWrites4,
  input  logic        r0writes4,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] wbData,
  output logic [15:0] r0data5,
  output logic [15:0] instructions5,
  output logic        regWrites5,
  output logic        r0writes5,
  output logic        mem_err
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_err_q, mem_err_d;
  // Captured op; the address itself lives in mem_addr_q.
  logic [15:0] r0data_h_q, r0data_h_d;
  logic [15:0] instr_h_q, instr_h_d;
  logic        ld_h_q, ld_h_d;
  logic        rw_h_q, rw_h_d;
  logic        r0w_h_q, r0w_h_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [15:0] r0data5_q, r0data5_d;
  logic [15:0] instr5_q, instr5_d;
  logic        rw5_q, rw5_d;
  logic        r0w5_q, r0w5_d;

  logic access;
  logic timeout;

  assign access  = wEnable | mux3sels4;
  assign timeout = (state_q == REQ) && (wait_cnt_q == 8'(ACK_TIMEOUT - 1)) && !mem_ack;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    r0data_h_d  = r0data_h_q;
    instr_h_d   = instr_h_q;
    ld_h_d      = ld_h_q;
    rw_h_d      = rw_h_q;
    r0w_h_d     = r0w_h_q;
    wb_data_d   = '0;
    r0data5_d   = '0;
    instr5_d    = '0;
    rw5_d       = 1'b0;
    r0w5_d      = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall       = 1'b1;
          state_d     = REQ;
          wait_cnt_d  = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = wEnable;
          mem_addr_d  = address;
          mem_wdata_d = Din;
          r0data_h_d  = r0data;
          instr_h_d   = instructions4;
          ld_h_d      = mux3sels4;
          rw_h_d      = regWrites4;
          r0w_h_d     = r0writes4;
        end else begin
          wb_data_d = address;
          r0data5_d = r0data;
          instr5_d  = instructions4;
          rw5_d     = regWrites4;
          r0w5_d    = r0writes4;
        end
      end
      REQ: begin
        stall = !mem_ack && !timeout;
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          wb_data_d = ld_h_q ? mem_rdata : mem_addr_q;
          r0data5_d = r0data_h_q;
          instr5_d  = instr_h_q;
          rw5_d     = rw_h_q;
          r0w5_d    = r0w_h_q;
        end else if (timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          wb_data_d = 16'hFFFF;
          r0data5_d = r0data_h_q;
          instr5_d  = instr_h_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      r0data_h_q  <= '0;
      instr_h_q   <= '0;
      ld_h_q      <= 1'b0;
      rw_h_q      <= 1'b0;
      r0w_h_q     <= 1'b0;
      wb_data_q   <= '0;
      r0data5_q   <= '0;
      instr5_q    <= '0;
      rw5_q       <= 1'b0;
      r0w5_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      r0data_h_q  <= r0data_h_d;
      instr_h_q   <= instr_h_d;
      ld_h_q      <= ld_h_d;
      rw_h_q      <= rw_h_d;
      r0w_h_q     <= r0w_h_d;
      wb_data_q   <= wb_data_d;
      r0data5_q   <= r0data5_d;
      instr5_q    <= instr5_d;
      rw5_q       <= rw5_d;
      r0w5_q      <= r0w5_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_err       = mem_err_q;
  assign wbData        = wb_data_q;
  assign r0data5       = r0data5_q;
  assign instructions5 = instr5_q;
  assign regWrites5    = rw5_q;
  assign r0writes5     = r0w5_q;

endmodule
